// File: rtl/ex_operand_stage.sv
// Execute-stage operand register: captures decoded instructions, resolves
// operand forwarding from EX/MEM/WB and detects load-use hazards.
module ex_operand_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_use_imm,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic [3:0]      id_alu_op,
    input  logic [XLEN-1:0] ex_fwd_result,
    input  logic [4:0]      mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_result,
    input  logic [4:0]      wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_result,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_op1,
    output logic [XLEN-1:0] ex_op2,
    output logic [XLEN-1:0] ex_store_data,
    output logic [3:0]      ex_alu_op,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic [15:0]     stall_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state;
    logic            load_use;
    logic            capture;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    assign ex_valid = (state == FULL);

    // A load still in this stage cannot feed its result to the next consumer.
    assign load_use = ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || ((ex_rd == id_rs2) && !id_use_imm));

    assign id_ready = (!ex_valid || ex_ready) && !load_use && !flush;
    assign capture  = id_valid && id_ready;

    // x0 is hardwired zero in the register file, so it is never forwarded.
    always_comb begin
        fwd_rs1 = id_rs1_data;
        if (id_rs1 != 5'd0) begin
            if (ex_valid && ex_reg_write && (ex_rd == id_rs1))
                fwd_rs1 = ex_fwd_result;
            else if (mem_reg_write && (mem_rd == id_rs1))
                fwd_rs1 = mem_result;
            else if (wb_reg_write && (wb_rd == id_rs1))
                fwd_rs1 = wb_result;
        end
    end

    always_comb begin
        fwd_rs2 = id_rs2_data;
        if (id_rs2 != 5'd0) begin
            if (ex_valid && ex_reg_write && (ex_rd == id_rs2))
                fwd_rs2 = ex_fwd_result;
            else if (mem_reg_write && (mem_rd == id_rs2))
                fwd_rs2 = mem_result;
            else if (wb_reg_write && (wb_rd == id_rs2))
                fwd_rs2 = wb_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= EMPTY;
            ex_op1        <= '0;
            ex_op2        <= '0;
            ex_store_data <= '0;
            ex_alu_op     <= '0;
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            stall_count   <= '0;
        end else begin
            if (id_valid && load_use && !flush && (stall_count != 16'hFFFF))
                stall_count <= stall_count + 16'd1;

            if (flush) begin
                state        <= EMPTY;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
            end else if (capture) begin
                state         <= FULL;
                ex_op1        <= fwd_rs1;
                ex_op2        <= id_use_imm ? id_imm : fwd_rs2;
                ex_store_data <= fwd_rs2;
                ex_alu_op     <= id_alu_op;
                ex_rd         <= id_rd;
                ex_reg_write  <= id_reg_write;
                ex_mem_read   <= id_mem_read;
            end else if (ex_valid && ex_ready) begin
                // Drain, or bubble behind a load-use stall.
                state        <= EMPTY;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed vector table, hand-written hazard /
// backpressure / reset sequences, then random traffic against a model.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_use_imm, id_reg_write, id_mem_read;
    logic [3:0]  id_alu_op;
    logic [31:0] ex_fwd_result;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_result, wb_result;
    logic        flush, ex_ready;
    logic        ex_valid;
    logic [31:0] ex_op1, ex_op2, ex_store_data;
    logic [3:0]  ex_alu_op;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read;
    logic [15:0] stall_count;

    int n_vec = 0;
    int n_err = 0;

    ex_operand_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_alu_op(id_alu_op),
        .ex_fwd_result(ex_fwd_result),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .flush(flush), .ex_ready(ex_ready),
        .ex_valid(ex_valid), .ex_op1(ex_op1), .ex_op2(ex_op2),
        .ex_store_data(ex_store_data), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_use_imm = 0; id_reg_write = 0; id_mem_read = 0; id_alu_op = 0;
        ex_fwd_result = 0; mem_rd = 0; wb_rd = 0;
        mem_reg_write = 0; wb_reg_write = 0; mem_result = 0; wb_result = 0;
        flush = 0; ex_ready = 1;
    endtask

    // Reference model: the instruction held in the stage as a plain record.
    logic        m_valid, m_rw, m_mr;
    logic [31:0] m_op1, m_op2, m_sd;
    logic [3:0]  m_op;
    logic [4:0]  m_rd;
    int          m_cnt;

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mr = 0; m_op1 = 0; m_op2 = 0; m_sd = 0;
        m_op = 0; m_rd = 0; m_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        set_idle();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        model_reset();
    endtask

    // Newest producer wins; x0 always reads the register file.
    function automatic logic [31:0] mdl_fwd(input logic [4:0] rs, input logic [31:0] rf);
        logic        en [3];
        logic [4:0]  rd [3];
        logic [31:0] val [3];
        en  = '{m_valid && m_rw, mem_reg_write, wb_reg_write};
        rd  = '{m_rd, mem_rd, wb_rd};
        val = '{ex_fwd_result, mem_result, wb_result};
        if (rs == 0) return rf;
        for (int k = 0; k < 3; k++)
            if (en[k] && rd[k] == rs) return val[k];
        return rf;
    endfunction

    typedef struct {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic        rw;
        logic [31:0] d1, d2;
        logic        ui;
        logic [31:0] imm, fwd;
        logic [4:0]  mrd;
        logic        mrw;
        logic [31:0] mres;
        logic [4:0]  wrd;
        logic        wrw;
        logic [31:0] wres;
        logic        e_rdy, e_vld;
        logic [31:0] e_op1, e_op2, e_sd;
    } vec_t;

    vec_t vt [6];

    initial begin
        rst_n = 0;
        set_idle();
        model_reset();
        #3;
        check("reset_valid", {31'b0, ex_valid}, 0);
        check("reset_op1", ex_op1, 0);
        check("reset_op2", ex_op2, 0);
        check("reset_rw_mr", {30'b0, ex_reg_write, ex_mem_read}, 0);
        check("reset_stall", {16'b0, stall_count}, 0);
        @(negedge clk) rst_n = 1;

        //        v rs1 rs2 rd rw  d1     d2     ui imm      fwd    mrd mrw mres      wrd wrw wres   rdy vld op1      op2      sd
        vt[0] = '{1, 1,  2,  3, 1, 32'd5, 32'd7, 0, 32'h0,  32'h0,  0, 0, 32'h0,     0, 0, 32'h0,  1, 1, 32'd5,   32'd7,   32'd7};
        vt[1] = '{1, 3,  4,  3, 0, 32'h99,32'd8, 0, 32'h0,  32'h10, 3, 1, 32'h20,    3, 1, 32'h30, 1, 1, 32'h10,  32'd8,   32'd8};
        vt[2] = '{1, 3,  3,  0, 1, 32'h99,32'h98,1, 32'h1234,32'h10,3, 1, 32'h20,    3, 1, 32'h30, 1, 1, 32'h20,  32'h1234,32'h20};
        vt[3] = '{1, 0,  9,  5, 1, 32'h0, 32'h77,0, 32'h0,  32'hBEEF,0,1, 32'hDEAD,  0, 1, 32'h31, 1, 1, 32'h0,   32'h77,  32'h77};
        vt[4] = '{1, 8,  8,  5, 1, 32'h1, 32'h2, 0, 32'h0,  32'h10, 2, 1, 32'h20,    8, 1, 32'h30, 1, 1, 32'h30,  32'h30,  32'h30};
        vt[5] = '{0, 5,  5,  0, 0, 32'h1, 32'h2, 0, 32'h0,  32'h10, 0, 0, 32'h0,     0, 0, 32'h0,  1, 0, 32'h0,   32'h0,   32'h0};

        for (int i = 0; i < 6; i++) begin
            id_valid = vt[i].v; id_rs1 = vt[i].rs1; id_rs2 = vt[i].rs2; id_rd = vt[i].rd;
            id_reg_write = vt[i].rw; id_mem_read = 0; id_alu_op = 4'(i);
            id_rs1_data = vt[i].d1; id_rs2_data = vt[i].d2;
            id_use_imm = vt[i].ui; id_imm = vt[i].imm; ex_fwd_result = vt[i].fwd;
            mem_rd = vt[i].mrd; mem_reg_write = vt[i].mrw; mem_result = vt[i].mres;
            wb_rd = vt[i].wrd; wb_reg_write = vt[i].wrw; wb_result = vt[i].wres;
            flush = 0; ex_ready = 1;
            #1;
            check($sformatf("vec%0d_id_ready", i), {31'b0, id_ready}, {31'b0, vt[i].e_rdy});
            @(posedge clk); #1;
            check($sformatf("vec%0d_ex_valid", i), {31'b0, ex_valid}, {31'b0, vt[i].e_vld});
            if (vt[i].e_vld) begin
                check($sformatf("vec%0d_ex_op1", i), ex_op1, vt[i].e_op1);
                check($sformatf("vec%0d_ex_op2", i), ex_op2, vt[i].e_op2);
                check($sformatf("vec%0d_store_data", i), ex_store_data, vt[i].e_sd);
            end
        end

        // Load-use: load to x5 held, consumer reads x5.
        do_reset();
        id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_rd = 5; id_reg_write = 1; id_mem_read = 1;
        id_rs1_data = 32'h11; id_rs2_data = 32'h22;
        #1 check("lu_load_ready", {31'b0, id_ready}, 1);
        @(posedge clk); #1;
        check("lu_load_held", {30'b0, ex_valid, ex_mem_read}, 3);
        id_rs1 = 5; id_rs2 = 0; id_rd = 6; id_mem_read = 0; id_rs1_data = 32'h55;
        #1 check("lu_ready_low", {31'b0, id_ready}, 0);
        @(posedge clk); #1;
        check("lu_bubble", {30'b0, ex_valid, ex_mem_read}, 0);
        check("lu_stall_count", {16'b0, stall_count}, 1);
        mem_rd = 5; mem_reg_write = 1; mem_result = 32'hABCD;
        #1 check("lu_ready_again", {31'b0, id_ready}, 1);
        @(posedge clk); #1;
        check("lu_capture_valid", {31'b0, ex_valid}, 1);
        check("lu_capture_op1", ex_op1, 32'hABCD);
        check("lu_stall_hold", {16'b0, stall_count}, 1);

        // Backpressure then flush.
        set_idle();
        id_valid = 1; id_rs1 = 1; id_rs1_data = 32'h111; id_rs2 = 2; id_rs2_data = 32'h222;
        id_rd = 7; id_reg_write = 1; id_alu_op = 4'h3;
        @(posedge clk); #1;
        check("bp_capture_op1", ex_op1, 32'h111);
        ex_ready = 0; id_rs1_data = 32'h999; id_rs2_data = 32'h888; id_rd = 9;
        for (int c = 0; c < 3; c++) begin
            #1 check("bp_id_ready", {31'b0, id_ready}, 0);
            @(posedge clk); #1;
            check("bp_valid", {31'b0, ex_valid}, 1);
            check("bp_op1", ex_op1, 32'h111);
            check("bp_op2", ex_op2, 32'h222);
            check("bp_rd_op", {23'b0, ex_rd, ex_alu_op}, {23'b0, 5'd7, 4'h3});
        end
        flush = 1;
        #1 check("fl_id_ready", {31'b0, id_ready}, 0);
        @(posedge clk); #1;
        check("fl_valid", {31'b0, ex_valid}, 0);
        check("fl_reg_write", {31'b0, ex_reg_write}, 0);
        flush = 0; id_valid = 0; ex_ready = 1;
        @(posedge clk); #1;
        check("fl_no_capture", {31'b0, ex_valid}, 0);

        // Asynchronous reset while FULL.
        set_idle();
        id_valid = 1; id_rs1 = 1; id_rs1_data = 32'h42; id_rd = 3; id_reg_write = 1;
        @(posedge clk); #1;
        check("ar_full", {31'b0, ex_valid}, 1);
        id_valid = 0; ex_ready = 0;
        #2 rst_n = 0;
        #1;
        check("ar_valid", {31'b0, ex_valid}, 0);
        check("ar_op1", ex_op1, 0);
        check("ar_reg_write", {31'b0, ex_reg_write}, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        check("ar_after", {31'b0, ex_valid}, 0);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic hz, rdy;
            logic [31:0] f1, f2;
            id_valid = ($urandom_range(0, 3) != 0);
            id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
            id_rd = 5'($urandom_range(0, 7));
            id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
            id_use_imm = $urandom_range(0, 1) == 1;
            id_reg_write = $urandom_range(0, 1) == 1;
            id_mem_read = ($urandom_range(0, 2) == 0);
            id_alu_op = 4'($urandom);
            ex_fwd_result = $urandom;
            mem_rd = 5'($urandom_range(0, 7)); mem_reg_write = $urandom_range(0, 1) == 1;
            mem_result = $urandom;
            wb_rd = 5'($urandom_range(0, 7)); wb_reg_write = $urandom_range(0, 1) == 1;
            wb_result = $urandom;
            flush = ($urandom_range(0, 9) == 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            #1;
            hz  = m_valid && m_mr && m_rd != 0 &&
                  (m_rd == id_rs1 || (!id_use_imm && m_rd == id_rs2));
            rdy = (!m_valid || ex_ready) && !hz && !flush;
            f1 = mdl_fwd(id_rs1, id_rs1_data);
            f2 = mdl_fwd(id_rs2, id_rs2_data);
            check("rnd_id_ready", {31'b0, id_ready}, {31'b0, rdy});
            @(posedge clk);
            if (id_valid && hz && !flush && m_cnt < 65535) m_cnt++;
            if (flush) m_valid = 0;
            else if (id_valid && rdy) begin
                m_valid = 1; m_op1 = f1; m_op2 = id_use_imm ? id_imm : f2; m_sd = f2;
                m_op = id_alu_op; m_rd = id_rd; m_rw = id_reg_write; m_mr = id_mem_read;
            end else if (m_valid && ex_ready) m_valid = 0;
            #1;
            check("rnd_valid", {31'b0, ex_valid}, {31'b0, m_valid});
            check("rnd_rw_mr", {30'b0, ex_reg_write, ex_mem_read},
                  {30'b0, m_valid && m_rw, m_valid && m_mr});
            check("rnd_stall_count", {16'b0, stall_count}, 32'(m_cnt));
            if (m_valid) begin
                check("rnd_op1", ex_op1, m_op1);
                check("rnd_op2", ex_op2, m_op2);
                check("rnd_store_data", ex_store_data, m_sd);
                check("rnd_rd_op", {23'b0, ex_rd, ex_alu_op}, {23'b0, m_rd, m_op});
            end
        end

        // Saturation: stalled consumer behind a load that cannot drain.
        do_reset();
        id_valid = 1; id_rs1 = 1; id_rd = 5; id_reg_write = 1; id_mem_read = 1;
        @(posedge clk); #1;
        id_rs1 = 5; id_rd = 6; id_mem_read = 0; ex_ready = 0;
        repeat (65534) @(posedge clk);
        #1 check("sat_fffe", {16'b0, stall_count}, 32'h0000FFFE);
        @(posedge clk); #1;
        check("sat_ffff", {16'b0, stall_count}, 32'h0000FFFF);
        repeat (2) @(posedge clk);
        #1 check("sat_hold", {16'b0, stall_count}, 32'h0000FFFF);
        check("sat_still_full", {31'b0, ex_valid}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of all operand and result ports.
REQ-002 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Ports id_valid in 1 / id_ready out 1: decode-to-stage handshake.
REQ-005 Ports id_rs1, id_rs2, id_rd in 5: register indices.
REQ-006 Ports id_rs1_data, id_rs2_data, id_imm in XLEN: register-file read data and immediate.
REQ-007 Ports id_use_imm, id_reg_write, id_mem_read in 1; id_alu_op in 4: decoded controls.
REQ-008 Ports ex_fwd_result in XLEN: ALU result of the instruction currently held.
REQ-009 Ports mem_rd / wb_rd in 5, mem_reg_write / wb_reg_write in 1, mem_result / wb_result in XLEN: later-stage writeback info.
REQ-010 Ports flush in 1 and ex_ready in 1: squash request and downstream accept.
REQ-011 Outputs ex_valid 1, ex_op1 / ex_op2 / ex_store_data XLEN, ex_alu_op 4, ex_rd 5, ex_reg_write 1, ex_mem_read 1: registered operands and controls to the ALU.
REQ-012 Output stall_count out 16: saturating count of load-use stall cycles.

Function
REQ-013 The stage SHALL be a single-entry register with states EMPTY (ex_valid=0) and FULL (ex_valid=1).
REQ-014 load_use SHALL be 1 when ex_valid=1, ex_mem_read=1, ex_rd!=0, and ex_rd equals id_rs1, or equals id_rs2 with id_use_imm=0.
REQ-015 id_ready SHALL equal (!ex_valid || ex_ready) && !load_use && !flush, combinationally.
REQ-016 Capture SHALL occur on an edge with id_valid && id_ready; latency from capture to ALU operands is exactly 1 cycle.
REQ-017 On an edge with ex_valid && ex_ready and no capture, the state SHALL go to EMPTY.
REQ-018 On an edge with a load-use stall and ex_ready=1, the stage SHALL insert a bubble: ex_valid=0, and the consumer stays stalled.
REQ-019 Operand forwarding for each source rsN SHALL use this priority:
- ex_fwd_result if ex_valid && ex_reg_write && ex_rd==rsN;
- else mem_result if mem_reg_write && mem_rd==rsN;
- else wb_result if wb_reg_write && wb_rd==rsN;
- else id_rsN_data.
REQ-020 Index 0 SHALL never be forwarded; operand is id_rsN_data (zero by register file).
REQ-021 ex_op1 SHALL capture the forwarded rs1 value.
REQ-022 ex_op2 SHALL capture id_imm if id_use_imm=1, else the forwarded rs2 value.
REQ-023 ex_store_data SHALL always capture the forwarded rs2 value.
REQ-024 ex_alu_op, ex_rd, ex_reg_write, ex_mem_read SHALL capture the id_ fields unmodified.
REQ-025 flush=1 SHALL force ex_valid=0 on the next edge, overriding capture and hold.
REQ-026 Datapath registers may retain stale values while EMPTY.
REQ-027 ex_reg_write and ex_mem_read SHALL be 0 whenever ex_valid=0.
REQ-028 stall_count SHALL increment on each edge where id_valid && load_use && !flush.
REQ-029 stall_count SHALL saturate at 16'hFFFF.
REQ-030 When FULL with ex_ready=0 and no flush, all outputs SHALL hold their values.

Reset
REQ-031 rst_n=0 SHALL immediately force ex_valid=0, ex_reg_write=0, ex_mem_read=0, stall_count=0.
REQ-032 rst_n=0 SHALL immediately force ex_op1=0, ex_op2=0, ex_store_data=0, ex_alu_op=0, ex_rd=0.
REQ-033 Reset mid-transfer SHALL drop the held instruction with no partial capture.
REQ-034 Deassertion SHALL take effect at the first rising edge after rst_n=1.

Verification
REQ-035 Bench SHALL cover basic capture:
- stimulus: id_rs1_data=5, id_rs2_data=7, no hazards, id_valid=1, ex_ready=1;
- response: next cycle ex_valid=1, ex_op1=5, ex_op2=7.
REQ-036 Bench SHALL cover forwarding priority:
- stimulus: rs1=3 matching EX (fwd=0x10), MEM (0x20) and WB (0x30);
- response: ex_op1=0x10;
- stimulus: same with EX not writing;
- response: ex_op1=0x20.
REQ-037 Bench SHALL cover load-use stall:
- stimulus: load to x5 held in stage, next instruction reads x5;
- response: id_ready=0 one cycle, a bubble is inserted, stall_count=1, then capture with mem_result forwarded.
REQ-038 Bench SHALL cover the x0 rule:
- stimulus: rs1=0 with mem_rd=0, mem_reg_write=1, mem_result=0xDEAD;
- response: ex_op1=id_rs1_data=0.
REQ-039 Bench SHALL cover backpressure and flush:
- stimulus: FULL with ex_ready=0 for 3 cycles;
- response: outputs stable and id_ready=0;
- stimulus: flush=1 with id_valid=1;
- response: ex_valid=0 next cycle, no capture.
REQ-040 Bench SHALL cover asynchronous reset:
- stimulus: assert rst_n=0 mid-cycle while FULL;
- response: ex_valid=0 without waiting for a clock edge.
